// File: rtl/uart_spi_bridge_if.sv
// rtl/uart_spi_bridge_if.sv - UART/SPI bridge signal bundle with master (bridge) and slave (environment) views
interface uart_spi_bridge_if #(
    parameter int DATA_WIDTH = 24
);
    logic [7:0]            RxData_I;
    logic                  RxValid_I;
    logic [7:0]            TxData_O;
    logic                  TxValid_O;
    logic                  TxBusy_I;
    logic                  SpiReq_O;
    logic [DATA_WIDTH-1:0] SpiData_O;
    logic [DATA_WIDTH-1:0] SpiData_I;
    logic                  SpiValid_I;
    logic                  SpiBusy_I;
    logic                  Overrun_O;
    logic                  Timeout_O;

    modport master (
        input  RxData_I, RxValid_I, TxBusy_I, SpiData_I, SpiValid_I, SpiBusy_I,
        output TxData_O, TxValid_O, SpiReq_O, SpiData_O, Overrun_O, Timeout_O
    );

    modport slave (
        output RxData_I, RxValid_I, TxBusy_I, SpiData_I, SpiValid_I, SpiBusy_I,
        input  TxData_O, TxValid_O, SpiReq_O, SpiData_O, Overrun_O, Timeout_O
    );
endinterface

// File: rtl/uart_spi_bridge.sv
// rtl/uart_spi_bridge.sv - UART byte stream to SPI word bridge; optional partial-word timeout via SPI_BRIDGE_TIMEOUT_EN
module uart_spi_bridge #(
    parameter int DATA_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              Clk_I,
    input  logic              RstP_I,
    uart_spi_bridge_if.master bus
);
    localparam logic [2:0] NBYTES = 3'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        COLLECT,
        REQ,
        WAIT,
        SEND,
        GUARD
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] resp_q;
    logic [DATA_WIDTH-1:0] spi_data_q;
    logic [DATA_WIDTH+7:0] asm_shift;
    logic [2:0]            rx_cnt;
    logic [2:0]            tx_cnt;
    logic [1:0]            req_cnt;
    logic                  overrun_q;
    logic                  timeout_q;
    logic                  rx_take;
    logic                  word_done;
    logic                  tx_fire;
    logic                  timeout_hit;

    // The new byte enters at the bottom; the oldest byte falls off the top.
    assign asm_shift = {asm_q, bus.RxData_I};
    assign rx_take   = (state == COLLECT) && bus.RxValid_I;
    assign word_done = rx_take && (rx_cnt + 3'd1 == NBYTES);
    assign tx_fire   = (state == SEND) && !bus.TxBusy_I;

`ifdef SPI_BRIDGE_TIMEOUT_EN
    logic [31:0] idle_cnt;

    assign timeout_hit = (state == COLLECT) && (rx_cnt != 3'd0) && !bus.RxValid_I
                         && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Idle cycles since the last byte of a partially assembled word.
    always_ff @(posedge Clk_I or posedge RstP_I) begin
        if (RstP_I) begin
            idle_cnt <= '0;
        end else if ((state != COLLECT) || (rx_cnt == 3'd0) || bus.RxValid_I || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // State register; reset drops straight back to COLLECT, which also drops SpiReq_O.
    always_ff @(posedge Clk_I or posedge RstP_I) begin
        if (RstP_I) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (word_done) state_nxt = REQ;
            // Hold the request at least 3 cycles so the master's 2-flop edge detector sees it.
            REQ:     if (bus.SpiBusy_I && (req_cnt == 2'd2)) state_nxt = WAIT;
            WAIT:    if (bus.SpiValid_I) state_nxt = SEND;
            SEND:    if (tx_fire) state_nxt = GUARD;
            GUARD:   state_nxt = (tx_cnt != 3'd0) ? SEND : COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        bus.SpiReq_O  = (state == REQ);
        bus.TxValid_O = tx_fire;
        bus.TxData_O  = resp_q[DATA_WIDTH-1 -: 8];
        bus.SpiData_O = spi_data_q;
        bus.Overrun_O = overrun_q;
        bus.Timeout_O = timeout_q;
    end

    // Word assembly from RX bytes, timeout discard, and SPI write word load.
    always_ff @(posedge Clk_I or posedge RstP_I) begin
        if (RstP_I) begin
            asm_q      <= '0;
            rx_cnt     <= '0;
            spi_data_q <= '0;
        end else if (rx_take) begin
            asm_q <= asm_shift[DATA_WIDTH-1:0];
            if (word_done) begin
                spi_data_q <= asm_shift[DATA_WIDTH-1:0];
                rx_cnt     <= '0;
            end else begin
                rx_cnt <= rx_cnt + 3'd1;
            end
        end else if (timeout_hit) begin
            asm_q  <= '0;
            rx_cnt <= '0;
        end
    end

    // Response capture and MSB-first byte unloading toward the UART TX.
    always_ff @(posedge Clk_I or posedge RstP_I) begin
        if (RstP_I) begin
            resp_q <= '0;
            tx_cnt <= '0;
        end else if ((state == WAIT) && bus.SpiValid_I) begin
            resp_q <= bus.SpiData_I;
            tx_cnt <= NBYTES;
        end else if (tx_fire) begin
            resp_q <= resp_q << 8;
            tx_cnt <= tx_cnt - 3'd1;
        end
    end

    // Request-length counter and the one-cycle status pulses.
    always_ff @(posedge Clk_I or posedge RstP_I) begin
        if (RstP_I) begin
            req_cnt   <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state != REQ) begin
                req_cnt <= '0;
            end else if (req_cnt != 2'd2) begin
                req_cnt <= req_cnt + 2'd1;
            end
            overrun_q <= bus.RxValid_I && (state != COLLECT);
            timeout_q <= timeout_hit;
        end
    end
endmodule

// File: tb/tb_uart_spi_bridge.sv
// tb/tb_uart_spi_bridge.sv - scoreboard bench for uart_spi_bridge with UART TX and SPI slave models
module tb_uart_spi_bridge;
    localparam int DW = 24;
    localparam int NB = DW / 8;
    localparam int TO = 100;

    logic Clk_I = 1'b0;
    logic RstP_I;

    uart_spi_bridge_if #(.DATA_WIDTH(DW)) bus ();

    uart_spi_bridge #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .Clk_I  (Clk_I),
        .RstP_I (RstP_I),
        .bus    (bus.master)
    );

    always #5 Clk_I = ~Clk_I;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_spi[$];
    logic [DW-1:0] rd_q[$];
    logic [7:0]    exp_tx[$];
    logic [7:0]    acc[$];
    logic [7:0]    burst[$];

    int exp_ovr = 0, seen_ovr = 0;
    int exp_to  = 0, seen_to  = 0;
    int ncyc = 0, last_tx_cyc = 0;
    bit long_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s wait bound expired got=timeout expected=event", name);
    endtask

    // Reference model: accepted bytes group into words MSB first; each word
    // yields one SPI write and its read word returns MSB byte first.
    task automatic accept_byte(input logic [7:0] b, input logic [DW-1:0] rd);
        logic [DW-1:0] w;
        acc.push_back(b);
        if (acc.size() == NB) begin
            w = '0;
            foreach (acc[i]) w = (w << 8) | DW'(acc[i]);
            exp_spi.push_back(w);
            rd_q.push_back(rd);
            for (int k = 0; k < NB; k++) exp_tx.push_back(8'(rd >> (8 * (NB - 1 - k))));
            acc.delete();
        end
    endtask

    // Wait until the previous word has fully drained plus the guard cycle, then gap cycles.
    task automatic wait_idle(input int gap);
        int n = 0;
        @(posedge Clk_I);
        while ((exp_tx.size() != 0 || exp_spi.size() != 0 || (ncyc + 1) < last_tx_cyc + 2 + gap) && n < 2000) begin
            @(posedge Clk_I);
            n++;
        end
        if (n >= 2000) bound_fail("wait_idle");
    endtask

    // Drive burst[] on consecutive cycles; call right after a rising edge.
    task automatic send_burst(input logic [DW-1:0] rd);
        foreach (burst[i]) begin
            #1;
            bus.RxData_I  = burst[i];
            bus.RxValid_I = 1'b1;
            accept_byte(burst[i], rd);
            @(posedge Clk_I);
        end
        #1 bus.RxValid_I = 1'b0;
    endtask

    task automatic wait_req_low();
        int n = 0;
        @(negedge Clk_I);
        while (bus.SpiReq_O && n < 200) begin
            @(negedge Clk_I);
            n++;
        end
        if (n >= 200) bound_fail("wait_req_low");
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [DW-1:0] rd, input int gap, input bit inject);
        wait_idle(gap);
        burst.delete();
        burst.push_back(b0);
        burst.push_back(b1);
        burst.push_back(b2);
        send_burst(rd);
        if (inject) begin
            wait_req_low();
            @(posedge Clk_I);
            #1;
            bus.RxData_I  = 8'hFF;
            bus.RxValid_I = 1'b1;
            exp_ovr++;
            @(posedge Clk_I);
            #1 bus.RxValid_I = 1'b0;
        end
    endtask

    // Environment: UART TX busy model and SPI slave, updated shortly after each rising edge.
    int   env_sst = 0, env_cnt = 0, env_hold = 0;
    logic env_req_s, env_txv_s;
    initial begin
        bus.TxBusy_I   = 1'b0;
        bus.SpiBusy_I  = 1'b0;
        bus.SpiValid_I = 1'b0;
        bus.SpiData_I  = '0;
        forever begin
            @(negedge Clk_I);
            env_req_s = bus.SpiReq_O;
            env_txv_s = bus.TxValid_O;
            @(posedge Clk_I);
            #2;
            if (RstP_I) begin
                env_sst = 0;
                env_hold = 0;
                rd_q.delete();
                bus.TxBusy_I   = 1'b0;
                bus.SpiBusy_I  = 1'b0;
                bus.SpiValid_I = 1'b0;
            end else begin
                if (env_txv_s) env_hold = $urandom_range(1, 6);
                else if (env_hold > 0) env_hold--;
                case (env_sst)
                    0: if (env_req_s) begin
                        if ($urandom_range(0, 1) == 1) begin
                            bus.SpiBusy_I = 1'b1;
                            env_sst = 2;
                            env_cnt = $urandom_range(4, 10);
                        end else begin
                            env_sst = 1;
                            env_cnt = $urandom_range(1, 3);
                        end
                    end
                    1: if (env_cnt > 1) env_cnt--;
                       else begin
                           bus.SpiBusy_I = 1'b1;
                           env_sst = 2;
                           env_cnt = $urandom_range(4, 10);
                       end
                    2: if (env_cnt > 1) env_cnt--;
                       else begin
                           bus.SpiBusy_I  = 1'b0;
                           bus.SpiValid_I = 1'b1;
                           if (rd_q.size() > 0) bus.SpiData_I = rd_q.pop_front();
                           else bound_fail("slave_read_word");
                           if (long_busy) env_hold = 50;
                           env_sst = 3;
                       end
                    default: begin
                        bus.SpiValid_I = 1'b0;
                        env_sst = 0;
                    end
                endcase
                bus.TxBusy_I = (env_hold != 0);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a request or a TX byte.
    logic          mon_prev_req = 1'b0, mon_prev_txv = 1'b0, mon_pending = 1'b0;
    int            mon_req_len = 0;
    logic [DW-1:0] mon_req_word;
    initial begin
        forever begin
            @(negedge Clk_I);
            ncyc++;
            if (RstP_I) begin
                exp_tx.delete();
                exp_spi.delete();
                mon_prev_req = 1'b0;
                mon_prev_txv = 1'b0;
                mon_pending  = 1'b0;
                continue;
            end
            if (bus.SpiReq_O) begin
                if (!mon_prev_req) begin
                    if (exp_spi.size() == 0) bound_fail("spi_req_unexpected");
                    else check("spi_word", 32'(bus.SpiData_O), 32'(exp_spi.pop_front()));
                    mon_req_word = bus.SpiData_O;
                    mon_req_len  = 1;
                end else begin
                    mon_req_len++;
                end
            end else if (mon_prev_req) begin
                check("req_min_len", 32'(mon_req_len >= 3), 32'd1);
                check("req_drop_on_busy", 32'(bus.SpiBusy_I), 32'd1);
                check("spi_data_held", 32'(bus.SpiData_O), 32'(mon_req_word));
            end
            mon_prev_req = bus.SpiReq_O;

            if (mon_pending && !bus.TxBusy_I) begin
                check("first_tx_latency", 32'(bus.TxValid_O), 32'd1);
                mon_pending = 1'b0;
            end
            if (bus.SpiValid_I) mon_pending = 1'b1;

            if (bus.TxValid_O) begin
                check("tx_while_busy", 32'(bus.TxBusy_I), 32'd0);
                check("tx_single_pulse", 32'(mon_prev_txv), 32'd0);
                if (exp_tx.size() == 0) bound_fail("tx_unexpected");
                else check("tx_byte", 32'(bus.TxData_O), 32'(exp_tx.pop_front()));
                last_tx_cyc = ncyc;
            end
            mon_prev_txv = bus.TxValid_O;
            if (bus.Overrun_O) seen_ovr++;
            if (bus.Timeout_O) seen_to++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RstP_I        = 1'b1;
        bus.RxValid_I = 1'b0;
        bus.RxData_I  = 8'h00;
        repeat (3) @(posedge Clk_I);
        #1;
        check("rst_spi_req", 32'(bus.SpiReq_O), 32'd0);
        check("rst_tx_valid", 32'(bus.TxValid_O), 32'd0);
        check("rst_tx_data", 32'(bus.TxData_O), 32'd0);
        check("rst_spi_data", 32'(bus.SpiData_O), 32'd0);
        check("rst_overrun", 32'(bus.Overrun_O), 32'd0);
        check("rst_timeout", 32'(bus.Timeout_O), 32'd0);
        @(posedge Clk_I);
        #1 RstP_I = 1'b0;

        send_word(8'hA5, 8'h5A, 8'h3C, DW'(24'h123456), 0, 1'b0);

        long_busy = 1'b1;
        send_word(8'hDE, 8'hAD, 8'hBE, DW'(24'hC0FFEE), 1, 1'b0);
        wait_idle(0);
        long_busy = 1'b0;

        send_word(8'hC0, 8'hDE, 8'h42, DW'(24'h0F1E2D), 0, 1'b1);
        send_word(8'h10, 8'h20, 8'h30, DW'(24'hABCDEF), 0, 1'b0);

        send_word(8'h01, 8'h02, 8'h03, DW'(24'h111111), 0, 1'b0);
        send_word(8'h04, 8'h05, 8'h06, DW'(24'h222222), 0, 1'b0);

`ifdef SPI_BRIDGE_TIMEOUT_EN
        wait_idle(0);
        burst.delete();
        burst.push_back(8'h11);
        burst.push_back(8'h22);
        send_burst(DW'(0));
        repeat (TO + 10) @(posedge Clk_I);
        acc.delete();
        exp_to++;
        send_word(8'h33, 8'h44, 8'h55, DW'(24'h987654), 0, 1'b0);
`endif

        send_word(8'h77, 8'h88, 8'h99, DW'(24'h5A5A5A), 0, 1'b0);
        wait_req_low();
        @(posedge Clk_I);
        #1 RstP_I = 1'b1;
        #1;
        check("midrst_spi_req", 32'(bus.SpiReq_O), 32'd0);
        check("midrst_tx_valid", 32'(bus.TxValid_O), 32'd0);
        check("midrst_spi_data", 32'(bus.SpiData_O), 32'd0);
        acc.delete();
        repeat (2) @(posedge Clk_I);
        #1 RstP_I = 1'b0;
        last_tx_cyc = 0;
        send_word(8'h3A, 8'hB7, 8'h0C, DW'(24'h13579B), 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            send_word(8'($urandom), 8'($urandom), 8'($urandom), DW'($urandom),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        wait_idle(0);
        repeat (20) @(posedge Clk_I);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check("spi_queue_drained", 32'(exp_spi.size()), 32'd0);
        check("read_queue_drained", 32'(rd_q.size()), 32'd0);
        check("overrun_pulses", 32'(seen_ovr), 32'(exp_ovr));
        check("timeout_pulses", 32'(seen_to), 32'(exp_to));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_spi_bridge.md
Name: uart_spi_bridge

Overview:
- Upstream command stage for the SPI master. Assembles bytes from the UART receiver into DATA_WIDTH-bit words, MSB byte first.
- Launches one SPI transfer per word and waits for completion.
- Returns the SPI read word to the UART transmitter, MSB byte first.
- Sits between the uart_rx/uart_tx pair and the SPI master in the top-level.

Parameters:
- DATA_WIDTH, 24, SPI word width; must be a multiple of 8 (8..32).
- TIMEOUT_CYCLES, 1000000, inter-byte idle limit in Clk_I cycles. Used only with SPI_BRIDGE_TIMEOUT_EN.

Ports:
- Clk_I  in  1  system clock.
- RstP_I  in  1  reset, asynchronous, active-high.
- RxData_I  in  8  received UART byte.
- RxValid_I  in  1  one-cycle strobe; RxData_I is valid.
- TxData_O  out  8  byte to transmit.
- TxValid_O  out  1  one-cycle strobe to the UART TX.
- TxBusy_I  in  1  UART TX busy.
- SpiReq_O  out  1  level request to the SPI master (WrRdReq_I).
- SpiData_O  out  DATA_WIDTH  write word to the SPI master (Data_I).
- SpiData_I  in  DATA_WIDTH  read word from the SPI master (Data_O).
- SpiValid_I  in  1  SPI read word valid (DataValid_O).
- SpiBusy_I  in  1  SPI master busy (Busy_O).
- Overrun_O  out  1  one-cycle pulse; an RX byte was dropped.
- Timeout_O  out  1  one-cycle pulse; a partial word was discarded.

Behaviour:
- Reset values: all outputs 0, SpiData_O = 0, state = COLLECT, byte counter = 0.
- States are COLLECT, REQ, WAIT, SEND, GUARD.

COLLECT:
- On RxValid_I, shift RxData_I into the low byte of the assembly register ({asm[DATA_WIDTH-9:0], RxData_I}) and increment the byte counter.
- When the counter reaches DATA_WIDTH/8 (that byte included):
  - load SpiData_O from the assembly register on the same edge;
  - clear the counter;
  - go to REQ.

REQ:
- SpiReq_O = 1.
- Stay in REQ until SpiBusy_I = 1, then drop SpiReq_O and go to WAIT.
- SpiReq_O is high for at least 3 cycles, because the master edge-detects the request through 2 flops.
- SpiData_O is held constant from loading until the next word is loaded.

WAIT:
- On SpiValid_I, capture SpiData_I into the response register, then go to SEND.
- SpiBusy_I falling without SpiValid_I is not a defined case and need not be handled.

SEND:
- When TxBusy_I = 0, pulse TxValid_O for 1 cycle with TxData_O = response[DATA_WIDTH-1 -: 8].
- Shift the response left by 8 and go to GUARD.

GUARD:
- One dead cycle, so the UART TX can raise busy.
- Then go to SEND if bytes remain, otherwise to COLLECT.

Dropped bytes:
- An RxValid_I in any state other than COLLECT drops the byte and pulses Overrun_O on the next cycle.
- The assembly register and counter are unaffected.

Latency:
- Last RX byte to SpiReq_O high: 1 cycle.
- SpiValid_I to first TxValid_O: 1 cycle if TxBusy_I = 0.

Boundary conditions:
- RxValid_I on the cycle the state returns to COLLECT is accepted.
- Reset mid-transfer returns everything to reset values immediately.
- SpiReq_O drops asynchronously on reset.

Optional Feature:
SPI_BRIDGE_TIMEOUT_EN:
- Defined:
  - A 32-bit idle counter runs in COLLECT while the byte counter is nonzero. It is cleared on each RxValid_I.
  - When it reaches TIMEOUT_CYCLES-1, the assembly register and byte counter clear and Timeout_O pulses for 1 cycle.
- Undefined:
  - A partial word is held indefinitely.
  - The counter logic is absent and Timeout_O is tied to 0.

Test Plan:
1. Reset, then RX bytes 0xA5, 0x5A, 0x3C with a slave model returning 0x123456 -> SpiData_O = 0xA55A3C. SpiReq_O is held until SpiBusy_I rises. TX sends 0x12, 0x34, 0x56 in order, one TxValid_O per byte.
2. TxBusy_I held high for 50 cycles after SpiValid_I -> no TxValid_O until TxBusy_I = 0. The first byte then goes out 1 cycle later.
3. A 4th RX byte 0xFF injected while in WAIT -> Overrun_O pulses once. The next word is assembled only from bytes received after returning to COLLECT.
4. Back-to-back 6 bytes 0x01..0x06 sent after the first response completes -> two transfers, SpiData_O = 0x010203 then 0x040506.
5. With SPI_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 100: send 0x11, 0x22, then idle 100 cycles -> Timeout_O pulses once. The following 0x33, 0x44, 0x55 gives SpiData_O = 0x334455.
6. Assert RstP_I during WAIT -> SpiReq_O = 0, TxValid_O = 0, state = COLLECT. A fresh 3-byte word then transfers normally.
